// File: rtl/load_store_unit.sv
// -----------------------------------------------------------------------------
// load_store_unit
//
// Sequences single load/store requests from the pipeline onto a simple
// strobe-based data memory and returns one response per request.
//
// Requests are checked on acceptance. The checks are, in priority order:
// illegal funct3, then misaligned address, then address out of range.
// A failing request goes straight to a response carrying the error code and
// never touches memory. A passing request holds the memory strobes for
// MEM_LATENCY cycles. mem_rdata is then sampled into the response.
// Sign/zero extension and byte-lane selection are done by the memory, so
// load data is passed through untouched.
//
// Ports
//   clk, reset                 clock, synchronous active-high reset
//   req_valid / req_ready      request handshake (ready only while idle)
//   req_we, req_funct3         1 = store; RISC-V width/sign code
//   req_addr, req_wdata        byte address, store data
//   req_rd                     destination tag, echoed on resp_rd
//   resp_valid / resp_ready    response handshake
//   resp_rdata                 load data (0 for stores and errors)
//   resp_rd, resp_err          tag; 00 ok, 01 misaligned, 10 range, 11 illegal
//   mem_addr, mem_wdata        memory address / write data
//   mem_mask                   funct3 of the access in flight
//   mem_wr_en, mem_rd_en       memory strobes
//   mem_rdata                  memory read data
// -----------------------------------------------------------------------------
module load_store_unit #(
   parameter int MEM_LATENCY = 1,     // strobe cycles before mem_rdata is sampled, 1..15
   parameter int MEM_WORDS   = 1024   // 32-bit words in the data memory
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [2:0]  req_funct3,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   input  logic [4:0]  req_rd,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic [31:0] resp_rdata,
   output logic [4:0]  resp_rd,
   output logic [1:0]  resp_err,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic [2:0]  mem_mask,
   output logic        mem_wr_en,
   output logic        mem_rd_en,
   input  logic [31:0] mem_rdata
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ACCESS,
      S_RESP
   } state_t;

   typedef enum logic [1:0] {
      ERR_OK       = 2'b00,
      ERR_MISALIGN = 2'b01,
      ERR_RANGE    = 2'b10,
      ERR_ILLEGAL  = 2'b11
   } err_t;

   localparam logic [3:0]  CNT_LOAD   = 4'(MEM_LATENCY - 1);
   localparam logic [32:0] ADDR_LIMIT = 33'(MEM_WORDS) * 33'd4;

   state_t     state;
   logic [3:0] cnt;      // remaining ACCESS cycles after this one; 0 outside ACCESS
   logic       lat_we;
   logic [4:0] lat_rd;

   // ---------------------------------------------------------------------------
   // Acceptance checks, evaluated on the request as presented
   // ---------------------------------------------------------------------------
   logic illegal;
   logic misaligned;
   logic out_of_range;
   err_t chk_err;

   always_comb begin
      // NOTE: every variable gets a default first so no path leaves it
      // unassigned, which would otherwise infer a latch.
      illegal = 1'b1;
      if (req_we) begin
         if (req_funct3 inside {3'b000, 3'b001, 3'b010}) illegal = 1'b0;
      end else begin
         if (req_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101}) illegal = 1'b0;
      end

      // funct3[1:0] = 01 is a halfword (LH/LHU/SH), 10 is a word (LW/SW).
      misaligned = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                   ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));

      out_of_range = ({1'b0, req_addr} >= ADDR_LIMIT);

      chk_err = ERR_OK;
      if (illegal)           chk_err = ERR_ILLEGAL;
      else if (misaligned)   chk_err = ERR_MISALIGN;
      else if (out_of_range) chk_err = ERR_RANGE;
   end

   // ---------------------------------------------------------------------------
   // Control FSM with registered outputs
   // ---------------------------------------------------------------------------
   // NOTE: sequential state uses non-blocking assignments only, so every
   // register samples pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= S_IDLE;
         cnt        <= '0;
         lat_we     <= 1'b0;
         lat_rd     <= '0;
         req_ready  <= 1'b0;
         resp_valid <= 1'b0;
         resp_rdata <= '0;
         resp_rd    <= '0;
         resp_err   <= ERR_OK;
         mem_addr   <= '0;
         mem_wdata  <= '0;
         mem_mask   <= '0;
         mem_wr_en  <= 1'b0;
         mem_rd_en  <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               // Ready rises one cycle after reset release and stays up while idle.
               req_ready <= 1'b1;
               if (req_valid && req_ready) begin
                  req_ready <= 1'b0;
                  lat_we    <= req_we;
                  lat_rd    <= req_rd;
                  if (chk_err != ERR_OK) begin
                     // Rejected requests respond at once and never strobe memory.
                     state      <= S_RESP;
                     resp_valid <= 1'b1;
                     resp_err   <= chk_err;
                     resp_rdata <= '0;
                     resp_rd    <= req_rd;
                  end else begin
                     state     <= S_ACCESS;
                     cnt       <= CNT_LOAD;
                     mem_addr  <= req_addr;
                     mem_wdata <= req_wdata;
                     mem_mask  <= req_funct3;
                     mem_rd_en <= ~req_we;
                     mem_wr_en <= req_we;
                  end
               end
            end

            S_ACCESS: begin
               // A store writes exactly once; a load keeps reading until sampled.
               mem_wr_en <= 1'b0;
               if (cnt == 4'd0) begin
                  state      <= S_RESP;
                  mem_addr   <= '0;
                  mem_wdata  <= '0;
                  mem_mask   <= '0;
                  mem_rd_en  <= 1'b0;
                  resp_valid <= 1'b1;
                  resp_err   <= ERR_OK;
                  resp_rd    <= lat_rd;
                  resp_rdata <= lat_we ? 32'h0 : mem_rdata;
               end else begin
                  cnt <= cnt - 4'd1;
               end
            end

            S_RESP: begin
               if (resp_ready) begin
                  state      <= S_IDLE;
                  req_ready  <= 1'b1;
                  resp_valid <= 1'b0;
                  resp_rdata <= '0;
                  resp_rd    <= '0;
                  resp_err   <= ERR_OK;
                  lat_we     <= 1'b0;
                  lat_rd     <= '0;
               end
            end

            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_load_store_unit.sv
// -----------------------------------------------------------------------------
// tb_load_store_unit
//
// Two units share the clock: instance 0 with MEM_LATENCY=1 and instance 1 with
// MEM_LATENCY=3. Each has its own word-organised memory model that performs
// lane selection and extension. Expectations come from a byte-addressed
// reference memory and the request rules (error priority, latency, strobe
// counts). Directed cases are followed by $urandom traffic and a reset taken
// in the middle of an access.
// -----------------------------------------------------------------------------
module tb_load_store_unit;

   localparam int MW = 1024;

   logic        clk;
   logic        reset      [2];
   logic        req_valid  [2];
   logic        req_ready  [2];
   logic        req_we     [2];
   logic [2:0]  req_funct3 [2];
   logic [31:0] req_addr   [2];
   logic [31:0] req_wdata  [2];
   logic [4:0]  req_rd     [2];
   logic        resp_valid [2];
   logic        resp_ready [2];
   logic [31:0] resp_rdata [2];
   logic [4:0]  resp_rd    [2];
   logic [1:0]  resp_err   [2];
   logic [31:0] mem_addr   [2];
   logic [31:0] mem_wdata  [2];
   logic [2:0]  mem_mask   [2];
   logic        mem_wr_en  [2];
   logic        mem_rd_en  [2];
   logic [31:0] mem_rdata  [2];

   for (genvar g = 0; g < 2; g++) begin : g_dut
      load_store_unit #(
         .MEM_LATENCY ((g == 0) ? 1 : 3),
         .MEM_WORDS   (MW)
      ) dut (
         .clk        (clk),
         .reset      (reset[g]),
         .req_valid  (req_valid[g]),
         .req_ready  (req_ready[g]),
         .req_we     (req_we[g]),
         .req_funct3 (req_funct3[g]),
         .req_addr   (req_addr[g]),
         .req_wdata  (req_wdata[g]),
         .req_rd     (req_rd[g]),
         .resp_valid (resp_valid[g]),
         .resp_ready (resp_ready[g]),
         .resp_rdata (resp_rdata[g]),
         .resp_rd    (resp_rd[g]),
         .resp_err   (resp_err[g]),
         .mem_addr   (mem_addr[g]),
         .mem_wdata  (mem_wdata[g]),
         .mem_mask   (mem_mask[g]),
         .mem_wr_en  (mem_wr_en[g]),
         .mem_rd_en  (mem_rd_en[g]),
         .mem_rdata  (mem_rdata[g])
      );
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------------------------------------------------------------------
   // Attached data memory: word array, word i holds i+1 after reset
   // ---------------------------------------------------------------------------
   logic [31:0] mem [2][MW];

   function automatic logic [31:0] lane_read(logic [31:0] word, logic [2:0] f3, logic [1:0] off);
      logic [31:0] sh;
      sh = word >> {off, 3'b000};
      case (f3)
         3'b000:  return {{24{sh[7]}}, sh[7:0]};
         3'b100:  return {24'h0, sh[7:0]};
         3'b001:  return {{16{sh[15]}}, sh[15:0]};
         3'b101:  return {16'h0, sh[15:0]};
         default: return word;
      endcase
   endfunction

   always @(posedge clk) begin
      for (int g = 0; g < 2; g++) begin
         if (reset[g]) begin
            for (int i = 0; i < MW; i++) mem[g][i] <= 32'(i + 1);
         end else if (mem_wr_en[g]) begin
            case (mem_mask[g])
               3'b000:  mem[g][mem_addr[g][11:2]][{mem_addr[g][1:0], 3'b000} +: 8] <= mem_wdata[g][7:0];
               3'b001:  mem[g][mem_addr[g][11:2]][{mem_addr[g][1], 4'b0000} +: 16] <= mem_wdata[g][15:0];
               default: mem[g][mem_addr[g][11:2]] <= mem_wdata[g];
            endcase
         end
      end
   end

   always_comb begin
      for (int g = 0; g < 2; g++) begin
         mem_rdata[g] = 32'h0;
         if (mem_rd_en[g])
            mem_rdata[g] = lane_read(mem[g][mem_addr[g][11:2]], mem_mask[g], mem_addr[g][1:0]);
      end
   end

   // ---------------------------------------------------------------------------
   // Reference model: byte-addressed memory plus the request rules
   // ---------------------------------------------------------------------------
   logic [7:0] ref_mem [2][MW*4];

   function automatic int lat_of(int g);
      return (g == 0) ? 1 : 3;
   endfunction

   task automatic ref_reset(int g);
      for (int i = 0; i < MW; i++) begin
         logic [31:0] w;
         w = 32'(i + 1);
         for (int b = 0; b < 4; b++) ref_mem[g][4*i + b] = w[8*b +: 8];
      end
   endtask

   function automatic logic [1:0] ref_err(bit we, logic [2:0] f3, logic [31:0] addr);
      bit legal;
      legal = we ? (f3 inside {3'd0, 3'd1, 3'd2}) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
      if (!legal) return 2'b11;
      if ((f3 == 3'd1 || f3 == 3'd5) && addr[0]) return 2'b01;
      if (f3 == 3'd2 && addr[1:0] != 2'b00) return 2'b01;
      if (addr >= 32'(MW*4)) return 2'b10;
      return 2'b00;
   endfunction

   function automatic logic [31:0] ref_load(int g, logic [2:0] f3, logic [31:0] addr);
      int a;
      logic [7:0] b0, b1, b2, b3;
      a  = int'(addr[11:0]);
      b0 = ref_mem[g][a];
      b1 = (a + 1 < MW*4) ? ref_mem[g][a+1] : 8'h0;
      b2 = (a + 2 < MW*4) ? ref_mem[g][a+2] : 8'h0;
      b3 = (a + 3 < MW*4) ? ref_mem[g][a+3] : 8'h0;
      case (f3)
         3'd0:    return {{24{b0[7]}}, b0};
         3'd4:    return {24'h0, b0};
         3'd1:    return {{16{b1[7]}}, b1, b0};
         3'd5:    return {16'h0, b1, b0};
         default: return {b3, b2, b1, b0};
      endcase
   endfunction

   task automatic ref_store(int g, logic [2:0] f3, logic [31:0] addr, logic [31:0] wdata);
      int a, n;
      a = int'(addr[11:0]);
      n = (f3 == 3'd0) ? 1 : (f3 == 3'd1) ? 2 : 4;
      for (int b = 0; b < n; b++) ref_mem[g][a + b] = wdata[8*b +: 8];
   endtask

   // ---------------------------------------------------------------------------
   // Checking
   // ---------------------------------------------------------------------------
   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   function automatic logic [9:0] out_flags(int g);
      return {req_ready[g], resp_valid[g], |resp_rdata[g], |resp_rd[g], |resp_err[g],
              |mem_addr[g], |mem_wdata[g], |mem_mask[g], mem_wr_en[g], mem_rd_en[g]};
   endfunction

   // One complete request/response transaction on instance g. Starts and ends
   // on a falling edge with the unit idle.
   task automatic run_req(input int g, input bit we, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [4:0] rd, input int stall, input string tag,
                          output logic [31:0] got_rdata);
      logic [1:0]  e_err;
      logic [31:0] e_rdata;
      int          e_k, k, rd_cyc, wr_cyc, bad_bus, bad_hold, waited;
      bit          got;

      e_err   = ref_err(we, f3, addr);
      e_rdata = (e_err == 2'b00 && !we) ? ref_load(g, f3, addr) : 32'h0;
      e_k     = (e_err == 2'b00) ? lat_of(g) : 0;

      @(negedge clk);
      req_valid[g]  = 1'b1;
      req_we[g]     = we;
      req_funct3[g] = f3;
      req_addr[g]   = addr;
      req_wdata[g]  = wdata;
      req_rd[g]     = rd;
      waited = 0;
      while (!req_ready[g] && waited < 20) begin
         @(negedge clk);
         waited++;
      end
      check({tag, "/req_ready"}, 32'(req_ready[g]), 32'd1);
      @(posedge clk);                 // accepting edge
      @(negedge clk);                 // first cycle after acceptance
      req_valid[g]  = 1'b0;
      req_we[g]     = 1'($urandom);
      req_funct3[g] = 3'($urandom);
      req_addr[g]   = $urandom;
      req_wdata[g]  = $urandom;
      req_rd[g]     = 5'($urandom);

      k = 0; rd_cyc = 0; wr_cyc = 0; bad_bus = 0; got = 1'b0;
      while (k <= 40) begin
         if (resp_valid[g]) begin
            got = 1'b1;
            break;
         end
         if (mem_rd_en[g]) rd_cyc++;
         if (mem_wr_en[g]) wr_cyc++;
         if ((mem_rd_en[g] || mem_wr_en[g]) &&
             (mem_addr[g] !== addr || mem_mask[g] !== f3 || (we && mem_wdata[g] !== wdata)))
            bad_bus++;
         if (req_ready[g]) bad_bus++;
         @(negedge clk);
         k++;
      end
      check({tag, "/resp_seen"}, 32'(got), 32'd1);
      check({tag, "/latency"}, 32'(k), 32'(e_k));
      check({tag, "/rd_cycles"}, 32'(rd_cyc), (!we && e_err == 2'b00) ? 32'(lat_of(g)) : 32'd0);
      check({tag, "/wr_cycles"}, 32'(wr_cyc), (we && e_err == 2'b00) ? 32'd1 : 32'd0);
      check({tag, "/bus"}, 32'(bad_bus), 32'd0);
      check({tag, "/resp_err"}, 32'(resp_err[g]), 32'(e_err));
      check({tag, "/resp_rdata"}, resp_rdata[g], e_rdata);
      check({tag, "/resp_rd"}, 32'(resp_rd[g]), 32'(rd));
      check({tag, "/mem_idle"}, 32'({mem_rd_en[g], mem_wr_en[g], |mem_addr[g], |mem_wdata[g], |mem_mask[g]}), 32'd0);
      got_rdata = resp_rdata[g];

      bad_hold = 0;
      for (int s = 0; s < stall; s++) begin
         @(negedge clk);
         if (!resp_valid[g] || resp_rdata[g] !== e_rdata || resp_rd[g] !== rd ||
             resp_err[g] !== e_err || req_ready[g] || mem_rd_en[g] || mem_wr_en[g])
            bad_hold++;
      end
      check({tag, "/hold"}, 32'(bad_hold), 32'd0);

      resp_ready[g] = 1'b1;
      @(posedge clk);
      @(negedge clk);
      resp_ready[g] = 1'b0;
      check({tag, "/release"}, 32'({resp_valid[g], req_ready[g]}), 32'b01);

      if (we && e_err == 2'b00) ref_store(g, f3, addr, wdata);
   endtask

   // ---------------------------------------------------------------------------
   // Stimulus
   // ---------------------------------------------------------------------------
   initial begin
      logic [31:0] r;
      int          bad;

      for (int g = 0; g < 2; g++) begin
         reset[g]      = 1'b1;
         req_valid[g]  = 1'b0;
         req_we[g]     = 1'b0;
         req_funct3[g] = 3'd0;
         req_addr[g]   = 32'h0;
         req_wdata[g]  = 32'h0;
         req_rd[g]     = 5'd0;
         resp_ready[g] = 1'b0;
         ref_reset(g);
      end

      repeat (3) @(negedge clk);
      for (int g = 0; g < 2; g++) check($sformatf("reset%0d/outputs", g), 32'(out_flags(g)), 32'd0);
      reset[0] = 1'b0;
      reset[1] = 1'b0;
      @(negedge clk);
      for (int g = 0; g < 2; g++) check($sformatf("reset%0d/ready_rise", g), 32'(req_ready[g]), 32'd1);

      // Directed, MEM_LATENCY = 1
      run_req(0, 1'b0, 3'b010, 32'h10, 32'h0, 5'd5, 0, "lw_0x10", r);
      check("lw_0x10/value", r, 32'h0000_0005);
      run_req(0, 1'b1, 3'b000, 32'h21, 32'hAB, 5'd3, 1, "sb_0x21", r);
      check("sb_0x21/value", r, 32'h0);
      run_req(0, 1'b0, 3'b100, 32'h21, 32'h0, 5'd4, 0, "lbu_0x21", r);
      check("lbu_0x21/value", r, 32'h0000_00AB);
      run_req(0, 1'b0, 3'b001, 32'h13, 32'h0, 5'd6, 0, "lh_misaligned", r);
      run_req(0, 1'b0, 3'b010, 32'h1000, 32'h0, 5'd7, 0, "lw_range", r);
      run_req(0, 1'b1, 3'b100, 32'h8, 32'h55, 5'd8, 0, "sw_illegal", r);
      run_req(0, 1'b0, 3'b011, 32'h1001, 32'h0, 5'd9, 0, "illegal_over_all", r);
      run_req(0, 1'b1, 3'b010, 32'h1002, 32'h0, 5'd10, 0, "misalign_over_range", r);
      run_req(0, 1'b0, 3'b010, 32'hFFC, 32'h0, 5'd11, 0, "lw_last_word", r);
      check("lw_last_word/value", r, 32'd1024);

      // Directed, MEM_LATENCY = 3, response back-pressured for 4 cycles
      run_req(1, 1'b0, 3'b010, 32'h0, 32'h0, 5'd1, 4, "lat3_lw_0x0", r);
      check("lat3_lw_0x0/value", r, 32'h0000_0001);

      // Randomized traffic on both instances
      for (int g = 0; g < 2; g++) begin
         for (int n = 0; n < 40; n++) begin
            logic [31:0] a;
            int          sel;
            sel = $urandom_range(0, 9);
            if (sel == 0)      a = 32'h1000 + $urandom_range(0, 255);
            else if (sel == 1) a = $urandom;
            else if (sel < 6)  a = $urandom_range(0, 63);
            else               a = $urandom_range(0, MW*4 - 1);
            if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
            run_req(g, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a, $urandom,
                    5'($urandom), $urandom_range(0, 3), $sformatf("rnd%0d_%0d", g, n), r);
         end
      end

      // Reset taken in the second ACCESS cycle of a MEM_LATENCY=3 load
      @(negedge clk);
      req_valid[1]  = 1'b1;
      req_we[1]     = 1'b0;
      req_funct3[1] = 3'b010;
      req_addr[1]   = 32'h40;
      req_rd[1]     = 5'd7;
      @(posedge clk);
      @(negedge clk);
      req_valid[1] = 1'b0;
      check("midrst/first_access", 32'(mem_rd_en[1]), 32'd1);
      @(negedge clk);
      reset[1] = 1'b1;
      @(negedge clk);
      check("midrst/outputs_zero", 32'(out_flags(1)), 32'd0);
      reset[1] = 1'b0;
      ref_reset(1);
      @(negedge clk);
      check("midrst/ready_after", 32'(req_ready[1]), 32'd1);
      bad = 0;
      for (int i = 0; i < 5; i++) begin
         if (resp_valid[1] || mem_rd_en[1] || mem_wr_en[1]) bad++;
         @(negedge clk);
      end
      check("midrst/no_response", 32'(bad), 32'd0);
      run_req(1, 1'b0, 3'b010, 32'h8, 32'h0, 5'd2, 0, "post_rst_lw", r);
      check("post_rst_lw/value", r, 32'h0000_0003);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
